// File: rtl/fm_phase_disc.sv
// FM phase discriminator: sequences samples through a serial CORDIC, differences
// consecutive phases and averages 2^DEC_LOG2 of them. Squelch: FM_PHASE_DISC_SQUELCH_EN.
module fm_phase_disc #(
  parameter int XY_WDT     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DEC_LOG2   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [XY_WDT-1:0]        xin,
  input  logic [XY_WDT-1:0]        yin,
  input  logic [XY_WDT-1:0]        sq_thr,
  output logic                     cord_st,
  output logic [XY_WDT-1:0]        cord_x,
  output logic [XY_WDT-1:0]        cord_y,
  input  logic                     cord_rdy,
  input  logic [XY_WDT-1:0]        cord_mag,
  input  logic signed [XY_WDT+1:0] cord_ph,
  output logic                     out_vld,
  output logic signed [XY_WDT+1:0] dph,
  output logic [XY_WDT-1:0]        out_mag
);

  localparam int PW    = XY_WDT + 2;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ACC_W = PW + DEC_LOG2;
  localparam int CW    = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'((1 << DEC_LOG2) - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BLANK,
    S_WAIT,
    S_CALC
  } state_t;

  state_t state_q, state_d;

  // Input FIFO
  logic [2*XY_WDT-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q;
  logic                rdy_en_q;
  logic                push, pop, empty, full;

  // CORDIC operands, captured results and averaging state
  logic [XY_WDT-1:0]       cord_x_q, cord_y_q;
  logic [XY_WDT-1:0]       mag_q;
  logic signed [PW-1:0]    ph_q, ph_prev_q;
  logic                    primed_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CW-1:0]           cnt_q;
  logic                    out_vld_q;
  logic signed [PW-1:0]    dph_q;
  logic [XY_WDT-1:0]       out_mag_q;

  logic                    capture, calc, last;
  logic signed [PW-1:0]    diff, diff_eff;
  logic signed [ACC_W-1:0] sum;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FIFO_FULL);
  assign in_rdy = rdy_en_q && !full;
  assign push   = in_vld && in_rdy;

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cord_st = 1'b0;
    pop     = 1'b0;
    capture = 1'b0;
    calc    = 1'b0;
    unique case (state_q)
      // The pop happens on entry to LAUNCH so cord_x/cord_y are valid alongside cord_st.
      S_IDLE: begin
        if (!empty && cord_rdy) begin
          pop     = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cord_st = 1'b1;
        state_d = S_BLANK;
      end
      S_BLANK: state_d = S_WAIT;
      S_WAIT: begin
        if (cord_rdy) begin
          capture = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        calc    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two's-complement wrap of the subtraction is exactly the [-pi, pi) fold.
  assign diff = ph_q - ph_prev_q;

`ifdef FM_PHASE_DISC_SQUELCH_EN
  assign diff_eff = (mag_q < sq_thr) ? '0 : diff;
`else
  logic unused_sq_thr;
  assign unused_sq_thr = ^sq_thr;
  assign diff_eff      = diff;
`endif

  assign sum  = acc_q + ACC_W'(diff_eff);
  assign last = (cnt_q == CNT_LAST);

  // NOTE: the sample store has no reset; the pointers and count alone say which
  // entries are valid, which lets the array map onto plain memory.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {xin, yin};
  end

  // NOTE: all state updates use non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rdy_en_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cord_x_q  <= '0;
      cord_y_q  <= '0;
      mag_q     <= '0;
      ph_q      <= '0;
      ph_prev_q <= '0;
      primed_q  <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      dph_q     <= '0;
      out_mag_q <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      count_q  <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q             <= rd_ptr_q + AW'(1);
        {cord_x_q, cord_y_q} <= mem_q[rd_ptr_q];
      end
      if (capture) begin
        mag_q <= cord_mag;
        ph_q  <= cord_ph;
      end
      out_vld_q <= 1'b0;
      if (calc) begin
        ph_prev_q <= ph_q;
        primed_q  <= 1'b1;
        // The first capture after reset only establishes the phase reference.
        if (primed_q) begin
          if (last) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b1;
            dph_q     <= sum[ACC_W-1:DEC_LOG2];
            out_mag_q <= mag_q;
          end else begin
            acc_q <= sum;
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end
    end
  end

  assign cord_x  = cord_x_q;
  assign cord_y  = cord_y_q;
  assign out_vld = out_vld_q;
  assign dph     = dph_q;
  assign out_mag = out_mag_q;

endmodule

// File: tb/tb_fm_phase_disc.sv
// Scoreboard bench for fm_phase_disc with a behavioural serial CORDIC model.
`timescale 1ns/1ps
module tb_fm_phase_disc;

  localparam int XY   = 16;
  localparam int PW   = XY + 2;
  localparam int BUSY = 18;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_vld = 1'b0;
  logic                 in_rdy;
  logic [XY-1:0]        xin = '0, yin = '0, sq_thr = '0;
  logic                 cord_st;
  logic [XY-1:0]        cord_x, cord_y;
  logic                 cord_rdy = 1'b1;
  logic [XY-1:0]        cord_mag = '0;
  logic signed [PW-1:0] cord_ph = '0;
  logic                 out_vld;
  logic signed [PW-1:0] dph;
  logic [XY-1:0]        out_mag;

  typedef struct {
    logic [XY-1:0] x;
    logic [XY-1:0] y;
    logic [XY-1:0] mag;
    logic [PW-1:0] ph;
  } samp_t;

  typedef struct {
    int dph;
    int mag;
  } exp_t;

  samp_t launch_q[$];
  exp_t  exp_q[$];
  samp_t cur;
  int    checks = 0, errors = 0;
  int    busy = 0, drop_dly = 0;
  bit    mon_en = 1'b0, late_drop = 1'b0;

  always #5 clk = ~clk;

  fm_phase_disc #(.XY_WDT(XY), .FIFO_DEPTH(4), .DEC_LOG2(2)) dut (
    .clk(clk), .reset(reset), .in_vld(in_vld), .in_rdy(in_rdy),
    .xin(xin), .yin(yin), .sq_thr(sq_thr),
    .cord_st(cord_st), .cord_x(cord_x), .cord_y(cord_y),
    .cord_rdy(cord_rdy), .cord_mag(cord_mag), .cord_ph(cord_ph),
    .out_vld(out_vld), .dph(dph), .out_mag(out_mag)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // CORDIC model: operands checked in launch order; with late_drop, rdy stays high
  // with stale results through the BLANK cycle.
  always @(negedge clk) begin
    if (drop_dly > 0) begin
      drop_dly--;
      if (drop_dly == 0) cord_rdy = 1'b0;
    end
    if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        cord_rdy = 1'b1;
        cord_mag = cur.mag;
        cord_ph  = cur.ph;
      end
    end
    if (cord_st === 1'b1) begin
      if (launch_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_launch: got cord_x=%0d expected no launch at %0t", cord_x, $time);
      end else begin
        cur = launch_q.pop_front();
        check("launch_cord_x", cord_x, cur.x);
        check("launch_cord_y", cord_y, cur.y);
      end
      busy = BUSY;
      if (late_drop) drop_dly = 2;
      else cord_rdy = 1'b0;
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (mon_en && out_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_vld: got dph=%0d expected no output at %0t", dph, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_dph", dph, e.dph);
        check("out_mag", out_mag, e.mag);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    in_vld = 1'b0;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input int x, input int y, input int m, input int p);
    samp_t s;
    int    n;
    n     = 0;
    s.x   = XY'(x);
    s.y   = XY'(y);
    s.mag = XY'(m);
    s.ph  = PW'(p);
    launch_q.push_back(s);
    in_vld = 1'b1;
    xin    = s.x;
    yin    = s.y;
    while (in_rdy !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        $display("FAIL send_timeout: got in_rdy=%b expected 1 at %0t", in_rdy, $time);
        $fatal(1);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n      = 0;
    in_vld = 1'b0;
    while ((launch_q.size() != 0 || exp_q.size() != 0 || busy != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", int'(n < 3000), 1);
    launch_q.delete();
    exp_q.delete();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int first_stall;
    int n;

    // Held reset with in_vld asserted
    in_vld = 1'b1;
    xin    = 16'h1234;
    yin    = 16'h5678;
    repeat (10) begin
      @(negedge clk);
      check("rst_in_rdy", in_rdy, 0);
      check("rst_cord_st", cord_st, 0);
      check("rst_cord_x", cord_x, 0);
      check("rst_cord_y", cord_y, 0);
      check("rst_out_vld", out_vld, 0);
      check("rst_dph", dph, 0);
      check("rst_out_mag", out_mag, 0);
    end
    in_vld = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check("in_rdy_after_release", in_rdy, 1);
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // Constant rotation of 4096 per sample, stale rdy during BLANK
    do_reset();
    late_drop = 1'b1;
    exp_q.push_back(exp_t'{4096, 1004});
    exp_q.push_back(exp_t'{4096, 1008});
    for (int i = 0; i < 9; i++) send(100 + i, 200 + i, 1000 + i, 4096 * i);
    drain();
    late_drop = 1'b0;

    // Wrap through +-pi, both directions
    do_reset();
    exp_q.push_back(exp_t'{22144, 1304});
    send(1, 2, 1300, 120000);
    send(3, 4, 1301, -120000);
    send(5, 6, 1302, -97856);
    send(7, 8, 1303, -75712);
    send(9, 10, 1304, -53568);
    drain();

    do_reset();
    exp_q.push_back(exp_t'{-22144, 1404});
    send(11, 12, 1400, -120000);
    send(13, 14, 1401, 120000);
    send(15, 16, 1402, 97856);
    send(17, 18, 1403, 75712);
    send(19, 20, 1404, 53568);
    drain();

    // Back-to-back burst of 8 against a 4-deep FIFO
    do_reset();
    exp_q.push_back(exp_t'{100, 2004});
    first_stall = -1;
    for (int i = 0; i < 8; i++) begin
      if (first_stall < 0 && in_rdy !== 1'b1) first_stall = i;
      send(16'h0A00 + i, 16'h0B00 + i, 2000 + i, 100 * i);
    end
    check("burst_accepts_before_full", first_stall, 5);
    drain();

    // Squelch: one low-magnitude sample in the group
    do_reset();
    sq_thr = 16'd100;
`ifdef FM_PHASE_DISC_SQUELCH_EN
    exp_q.push_back(exp_t'{3072, 1004});
`else
    exp_q.push_back(exp_t'{4096, 1004});
`endif
    for (int i = 0; i < 5; i++) send(30 + i, 40 + i, (i == 2) ? 50 : 1000 + i, 4096 * i);
    drain();

    // Reset while the CORDIC is busy: result discarded, reference re-primed
    do_reset();
    send(7, 7, 777, 50000);
    in_vld = 1'b0;
    n = 0;
    while (cord_rdy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cordic_busy_before_reset", cord_rdy, 0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.push_back(exp_t'{4096, 1504});
    for (int i = 0; i < 5; i++) send(50 + i, 60 + i, 1500 + i, 4096 * i);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish by %0t", $time);
    $fatal(1);
  end

endmodule
